keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front end for the 4x4 matrix keypad.
- Drives the column lines one at a time, samples the row lines, debounces across full scans and resolves exactly one pressed key into a 4-bit key code.
- Announces each new key with a one-cycle valid pulse and a level "held" flag.
- Sits between the keypad pins and the key decode/Nios PIO logic, replacing raw row sampling.

Parameters:
- SCAN_DIV, 12000: clk cycles each column is driven (dwell); legal minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release; legal minimum 1.
- REPEAT_SCANS, 64: full scans between repeat pulses; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rows  input  4  keypad row lines, active-low (external pull-ups); asynchronous to clk
- columns  output  4  column drive, active-low one-cold; bit0 = leftmost column
- key  output  4  code of the accepted key; holds its value until the next accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while the accepted key remains pressed (debounced)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the posedge of clk.
- Reset values:
  - columns = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0
  - state IDLE; dwell counter, column index and scan accumulator cleared
  - debounce and repeat counters cleared
- Synchronization: rows pass through a 2-flop synchronizer before use.
- Row sampling: rows are sampled on the last cycle of each dwell (counter == SCAN_DIV-1). Dwell cycle 0 is the first cycle the new column is driven.
- Column sequence: columns rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110. A full scan = 4*SCAN_DIV cycles and ends at the col3 sample.
- Key map (row r low while column c driven), codes in hex:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Scan result per full scan: exactly one row-low over all four columns gives KEY(code); zero lows gives NONE; two or more lows (any columns) gives MULTI, treated as NONE (ghost-safe).
- The FSM evaluates once per full scan, on the cycle after the col3 sample:
  - IDLE:
    - result KEY(k) -> cand=k, cnt=1.
    - If cnt reaches DEBOUNCE_SCANS, go to PRESSED; otherwise go to DEB_PRESS.
  - DEB_PRESS:
    - KEY(cand) -> cnt+1.
    - At DEBOUNCE_SCANS -> PRESSED.
    - KEY(other) -> cand=other, cnt=1.
    - NONE -> IDLE.
  - Entering PRESSED: key<=cand, key_valid=1 for exactly that cycle, key_held<=1.
  - PRESSED:
    - KEY(key) -> stay.
    - Anything else -> DEB_RELEASE, cnt=1 (or straight to IDLE if DEBOUNCE_SCANS==1).
  - DEB_RELEASE:
    - Result != KEY(key) -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held<=0.
    - KEY(key) -> PRESSED with no new pulse.
- Release never pulses key_valid. key retains the last code after release.
- A different key pressed while one is held is accepted only after the full release debounce and a fresh press debounce.
- Latency: key_valid rises 1 cycle after the sample that completes the DEBOUNCE_SCANS-th matching scan.
- Reset mid-operation discards the in-flight scan and the debounce history. A key still physically held is re-accepted after DEBOUNCE_SCANS scans.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined: in PRESSED, a repeat counter advances once per full scan. Every REPEAT_SCANS scans it re-pulses key_valid (1 cycle) with key unchanged. The counter clears on entry to PRESSED and whenever PRESSED is left.
- When undefined: exactly one key_valid per press; no repeat counter logic is synthesized.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (full scan = 16 cycles), with the keypad modelled combinationally from columns.
1. Hold rst for 3 cycles, then release -> columns=4'b1110, key=0, key_valid=0, key_held=0; columns then walk 1101, 1011, 0111 at 4-cycle intervals.
2. Press '5' (row1 low when col1 driven) steadily -> exactly one key_valid pulse with key=4'h5, after the 3rd complete scan; key_held=1 and stays 1.
3. Press '9' for 2 scans, release for 1 scan, press again for 3 scans -> no pulse during the bounce; a single pulse with key=4'h9 only after 3 consecutive matching scans.
4. Press '1' and '2' together -> no key_valid; release '2' while keeping '1' -> pulse with key=4'h1 after 3 scans.
5. From PRESSED with '#', release -> key_held drops after 3 NONE scans; no pulse; key stays 4'hF. A 1-scan release glitch keeps key_held=1.
6. Assert rst while 'D' is held in PRESSED -> all outputs are at reset values the next cycle; a new pulse with key=4'hD follows after 3 scans. With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS=2 -> pulses repeat every 32 cycles while held.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with scan-level debounce and a one-cycle key_valid pulse per accepted key
//   clk, rst           : clock, synchronous active-high reset
//   rows               : row lines, active-low, asynchronous
//   columns            : one-cold column drive, bit0 = leftmost column
//   key                : last accepted key code
//   key_valid          : one-cycle pulse per accepted key
//   key_held           : debounced "accepted key still down" level
// Optional: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_SCANS scans while held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  // nibble (row*4 + col) holds the code of that matrix position
  localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
  state_t        state_q;
  logic [3:0]    rows_m_q, rows_s_q, cand_q, key_q, acc_q, acc_d;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q, nlow_q, nlow_d;
  logic [BW-1:0] deb_q, deb_inc;
  logic          valid_q, held_q, sample, scan_end, hit, same, match, deb_full;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rpt_q;
`endif
  assign columns   = ~(4'b0001 << col_q);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  // nlow saturates at 2: any second low row anywhere in the scan makes it ambiguous
  always_comb begin
    acc_d  = acc_q;
    nlow_d = nlow_q;
    for (int r = 0; r < 4; r++)
      if (!rows_s_q[r]) begin
        acc_d  = KMAP[{2'(r), col_q, 2'b00} +: 4];
        nlow_d = (nlow_d == 2'd0) ? 2'd1 : 2'd2;
      end
    sample   = dwell_q == DW'(SCAN_DIV - 1);
    scan_end = sample && col_q == 2'd3;
    hit      = nlow_d == 2'd1;
    same     = hit && acc_d == key_q;
    match    = hit && acc_d == cand_q;
    deb_inc  = deb_q + 1'b1;
    deb_full = deb_inc >= BW'(DEBOUNCE_SCANS);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
      dwell_q  <= '0;
      col_q    <= '0;
      nlow_q   <= '0;
      acc_q    <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      deb_q    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q    <= '0;
`endif
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
      valid_q  <= 1'b0;
      dwell_q  <= sample ? '0 : dwell_q + 1'b1;
      if (sample) begin
        col_q  <= col_q + 2'd1;
        nlow_q <= scan_end ? 2'd0 : nlow_d;
        acc_q  <= scan_end ? 4'h0 : acc_d;
      end
      if (scan_end)
        case (state_q)
          IDLE:
            if (hit) begin
              cand_q <= acc_d;
              deb_q  <= BW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state_q <= PRESSED;
                key_q   <= acc_d;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
              end else state_q <= DEB_PRESS;
            end
          DEB_PRESS:
            if (match) begin
              deb_q <= deb_inc;
              if (deb_full) begin
                state_q <= PRESSED;
                key_q   <= cand_q;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
              end
            end else if (hit) begin
              cand_q <= acc_d;
              deb_q  <= BW'(1);
            end else begin
              state_q <= IDLE;
              deb_q   <= '0;
            end
          PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q <= (same && rpt_q != RW'(REPEAT_SCANS - 1)) ? rpt_q + 1'b1 : '0;
            if (same && rpt_q == RW'(REPEAT_SCANS - 1)) valid_q <= 1'b1;
`endif
            if (!same) begin
              state_q <= (DEBOUNCE_SCANS == 1) ? IDLE : DEB_RELEASE;
              deb_q   <= BW'(1);
              held_q  <= DEBOUNCE_SCANS != 1;
            end
          end
          DEB_RELEASE:
            if (same) state_q <= PRESSED;
            else begin
              deb_q <= deb_inc;
              if (deb_full) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
                deb_q   <= '0;
              end
            end
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans)
module tb_keypad_scanner;
  typedef struct {logic [3:0] k; int c;} exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows, columns, key;
  logic        key_valid, key_held;
  logic [15:0] press = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          kcode [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  exp_t        q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(2)) dut (
    .clk(clk), .rst(rst), .rows(rows), .columns(columns),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!columns[c] && press[r*4+c]) rows[r] = 1'b0;
  end

  always @(negedge clk)
    if (!rst && key_valid) begin
      n_chk++;
      if (q.size() == 0) $display("FAIL unexpected_pulse key=%h cycle=%0d required no pulse", key, cyc);
      else begin
        exp_t e;
        e = q.pop_front();
        if (key !== e.k || cyc != e.c || key_held !== 1'b1)
          $display("FAIL pulse key=%h cycle=%0d held=%b required key=%h cycle=%0d held=1", key, cyc, key_held, e.k, e.c);
        else n_pass++;
      end
    end

  task automatic at_scan();
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic expect_key(input int p, input int s);
    exp_t e;
    e.k = 4'(kcode[p]);
    e.c = 16 * s;
    q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_chk++;
    if (q.size() != 0) $display("FAIL %s pending_pulses=%0d required 0", name, q.size());
    else n_pass++;
  endtask

  task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
    n_chk++;
    if (got !== req) $display("FAIL %s got=%h required=%h", name, got, req);
    else n_pass++;
  endtask

  task automatic release_all();
    int r;
    at_scan();
    r = cyc / 16;
    press = '0;
    repeat (47) @(negedge clk);
    n_chk++;
    if (key_held !== 1'b1) $display("FAIL held_before_release_done got=%b required=1", key_held);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (key_held !== 1'b0 || cyc != 16 * (r + 3)) $display("FAIL held_after_release got=%b cycle=%0d required=0 cycle=%0d", key_held, cyc, 16 * (r + 3));
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols [3] = '{4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1;
    press = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("reset_columns", columns, 4'b1110);
    check_val("reset_key", key, 4'h0);
    check_val("reset_valid", {3'b0, key_valid}, 4'h0);
    check_val("reset_held", {3'b0, key_held}, 4'h0);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      check_val("column_walk", columns, exp_cols[i]);
    end
  endtask

  task automatic test_press();
    at_scan();
    press = 16'(1) << 5;
    expect_key(5, cyc / 16 + 3);
    scans(4);
    check_drained("press5");
    check_val("press5_key", key, 4'h5);
    check_val("press5_held", {3'b0, key_held}, 4'h1);
    release_all();
  endtask

  task automatic test_bounce();
    at_scan();
    press = 16'(1) << 10;
    scans(2);
    press = '0;
    scans(1);
    press = 16'(1) << 10;
    expect_key(10, cyc / 16 + 3);
    scans(4);
    check_drained("bounce9");
    check_val("bounce9_key", key, 4'h9);
    release_all();
  endtask

  task automatic test_multi();
    at_scan();
    press = 16'h0003;
    scans(4);
    check_val("multi_key_unchanged", key, 4'h9);
    press = 16'h0001;
    expect_key(0, cyc / 16 + 3);
    scans(4);
    check_drained("multi_then_1");
    check_val("multi_key1", key, 4'h1);
    release_all();
  endtask

  task automatic test_release_glitch();
    at_scan();
    press = 16'(1) << 14;
    expect_key(14, cyc / 16 + 3);
    scans(4);
    check_drained("press_hash");
    press = '0;
    scans(1);
    press = 16'(1) << 14;
    scans(2);
    check_val("glitch_held", {3'b0, key_held}, 4'h1);
    check_val("glitch_key", key, 4'hF);
    release_all();
    check_val("release_key_kept", key, 4'hF);
    check_drained("release_no_pulse");
  endtask

  task automatic test_reset_mid();
    at_scan();
    press = 16'(1) << 15;
    expect_key(15, cyc / 16 + 3);
    scans(4);
    check_drained("pressD");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midreset_columns", columns, 4'b1110);
    check_val("midreset_key", key, 4'h0);
    check_val("midreset_valid", {3'b0, key_valid}, 4'h0);
    check_val("midreset_held", {3'b0, key_held}, 4'h0);
    rst = 1'b0;
    expect_key(15, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
    expect_key(15, 5);
`endif
    scans(6);
    check_drained("reaccept_D");
    check_val("reaccept_key", key, 4'hD);
    release_all();
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_release_glitch();
    test_reset_mid();
    scans(2);
    check_drained("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
